// File: rtl/led_display_arbiter.sv
// led_display_arbiter
// Shares one 4-digit hex LED display between four requesters. The display is
// granted round-robin. Each grant is held for a minimum dwell time. The granted
// source's 16-bit value is driven to the display driver's dataIn.
//
// Ports:
//   gclock   - system clock
//   greset   - synchronous active-high reset
//   req      - per-source display request (bit i = source i)
//   reqData  - source data, source i at [16*i+15:16*i]
//   grant    - registered one-hot grant, 0 when idle
//   dataOut  - registered word to the display driver
//   slotDone - one-cycle pulse to the source whose slot just ended
//   busy     - high while a source owns the display
module led_display_arbiter #(
    parameter int DWELL_CYCLES = 25000000,
    parameter int CNT_W        = 25
) (
    input  logic        gclock,
    input  logic        greset,
    input  logic [3:0]  req,
    input  logic [63:0] reqData,
    output logic [3:0]  grant,
    output logic [15:0] dataOut,
    output logic [3:0]  slotDone,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t             state_q, state_d;
    logic [3:0]         grant_q, grant_d;
    logic [15:0]        data_q, data_d;
    logic [3:0]         slot_q, slot_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         ptr_q, ptr_d;

    logic [3:0][15:0]   slice;
    logic               found;
    logic [1:0]         win;
    logic [1:0]         idx;

    assign slice = reqData;

    // Round-robin search starting just after the last grant. The pointer
    // itself is checked last, so while SHOW the current owner has lowest
    // priority at slot end.
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        data_d  = data_q;
        slot_d  = 4'b0000;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = SHOW;
                    grant_d = 4'b0001 << win;
                    ptr_d   = win;
                    data_d  = slice[win];
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SHOW: begin
                // In SHOW the pointer always names the current owner.
                // The display freezes while the owner withdraws its request.
                if (req[ptr_q])
                    data_d = slice[ptr_q];
                if (cnt_q == CNT_END) begin
                    slot_d[ptr_q] = 1'b1;
                    cnt_d         = '0;
                    if (found) begin
                        // Covers both hand-off and re-grant to the same source.
                        grant_d = 4'b0001 << win;
                        ptr_d   = win;
                        data_d  = slice[win];
                    end else begin
                        // Nobody wants the display; the last value stays shown.
                        state_d = IDLE;
                        grant_d = 4'b0000;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gclock) begin
        if (greset) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            data_q  <= 16'h0000;
            slot_q  <= 4'b0000;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= 2'd3;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            slot_q  <= slot_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant    = grant_q;
    assign dataOut  = data_q;
    assign slotDone = slot_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_led_display_arbiter.sv
// Bench for led_display_arbiter with a 4-cycle dwell. Each driven cycle pushes
// the hand-derived outputs expected after the next clock edge. A monitor pops
// one entry per edge and compares it against the DUT.
module tb_led_display_arbiter;

    logic        gclock;
    logic        greset;
    logic [3:0]  req;
    logic [63:0] reqData;
    logic [3:0]  grant;
    logic [15:0] dataOut;
    logic [3:0]  slotDone;
    logic        busy;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  g;
        logic [15:0] d;
        logic [3:0]  s;
        logic        b;
        string       tag;
    } exp_t;

    exp_t sb[$];

    led_display_arbiter #(.DWELL_CYCLES(4), .CNT_W(3)) dut (
        .gclock   (gclock),
        .greset   (greset),
        .req      (req),
        .reqData  (reqData),
        .grant    (grant),
        .dataOut  (dataOut),
        .slotDone (slotDone),
        .busy     (busy)
    );

    initial gclock = 1'b0;
    always #5 gclock = ~gclock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the edge.
    task automatic cyc(input logic rst, input logic [3:0] r, input logic [63:0] d,
                       input logic [3:0] eg, input logic [15:0] ed,
                       input logic [3:0] es, input logic eb, input string tag);
        exp_t e;
        @(negedge gclock);
        greset  = rst;
        req     = r;
        reqData = d;
        e.g = eg; e.d = ed; e.s = es; e.b = eb; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic do_reset(input string tag);
        cyc(1'b1, 4'b0000, 64'h0, 4'b0000, 16'h0000, 4'b0000, 1'b0, tag);
        cyc(1'b1, 4'b0000, 64'h0, 4'b0000, 16'h0000, 4'b0000, 1'b0, tag);
    endtask

    initial begin
        forever begin
            @(posedge gclock);
            #1;
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, ".grant"}, 32'(grant),    32'(e.g));
                chk({e.tag, ".data"},  32'(dataOut),  32'(e.d));
                chk({e.tag, ".slot"},  32'(slotDone), 32'(e.s));
                chk({e.tag, ".busy"},  32'(busy),     32'(e.b));
            end
        end
    end

    localparam logic [63:0] D12 = 64'h0000_5678_0000_1234;
    localparam logic [63:0] D4  = 64'h4444_3333_2222_1111;

    initial begin
        greset  = 1'b1;
        req     = 4'b0000;
        reqData = 64'h0;

        do_reset("rst");

        // Single requester: grant after one cycle, slot pulse every 4 cycles.
        for (int k = 1; k <= 9; k++)
            cyc(1'b0, 4'b0001, D12, 4'b0001, 16'h1234,
                (k == 5 || k == 9) ? 4'b0001 : 4'b0000, 1'b1, "single");

        // Sources 0 and 2 both held: hand-off to 2, then back to 0.
        for (int k = 10; k <= 17; k++) begin
            if (k < 13)
                cyc(1'b0, 4'b0101, D12, 4'b0001, 16'h1234, 4'b0000, 1'b1, "rr02");
            else if (k == 13)
                cyc(1'b0, 4'b0101, D12, 4'b0100, 16'h5678, 4'b0001, 1'b1, "rr02");
            else if (k < 17)
                cyc(1'b0, 4'b0101, D12, 4'b0100, 16'h5678, 4'b0000, 1'b1, "rr02");
            else
                cyc(1'b0, 4'b0101, D12, 4'b0001, 16'h1234, 4'b0100, 1'b1, "rr02");
        end
        // All requests gone: dwell completes, then idle with frozen data.
        for (int k = 18; k <= 20; k++)
            cyc(1'b0, 4'b0000, D12, 4'b0001, 16'h1234, 4'b0000, 1'b1, "drop");
        cyc(1'b0, 4'b0000, D12, 4'b0000, 16'h1234, 4'b0001, 1'b0, "drop");
        cyc(1'b0, 4'b0000, D12, 4'b0000, 16'h1234, 4'b0000, 1'b0, "idle");

        // All four requesting from reset: 0,1,2,3,0, four cycles each.
        do_reset("rst4");
        for (int k = 1; k <= 17; k++) begin
            int src;
            logic [3:0] es;
            logic [15:0] ed;
            src = ((k - 1) / 4) % 4;
            es  = (k > 1 && (k - 1) % 4 == 0) ? (4'b0001 << ((src + 3) % 4)) : 4'b0000;
            ed  = 16'h1111 * 16'(src + 1);
            cyc(1'b0, 4'b1111, D4, 4'b0001 << src, ed, es, 1'b1, "all4");
        end

        // Source 1 tracks, then withdraws: data frozen, dwell still completes.
        do_reset("rst1");
        cyc(1'b0, 4'b0010, 64'h0000_0000_AAAA_0000, 4'b0010, 16'hAAAA, 4'b0000, 1'b1, "wd");
        cyc(1'b0, 4'b0010, 64'h0000_0000_AAAB_0000, 4'b0010, 16'hAAAB, 4'b0000, 1'b1, "wd");
        cyc(1'b0, 4'b0000, 64'h0000_0000_CCCC_0000, 4'b0010, 16'hAAAB, 4'b0000, 1'b1, "wd");
        cyc(1'b0, 4'b0000, 64'h0000_0000_DDDD_0000, 4'b0010, 16'hAAAB, 4'b0000, 1'b1, "wd");
        cyc(1'b0, 4'b0000, 64'h0000_0000_EEEE_0000, 4'b0000, 16'hAAAB, 4'b0010, 1'b0, "wd");
        cyc(1'b0, 4'b0000, 64'h0000_0000_EEEE_0000, 4'b0000, 16'hAAAB, 4'b0000, 1'b0, "wd");

        // Source 3 data changes mid-slot while requesting.
        do_reset("rst3");
        cyc(1'b0, 4'b1000, 64'hBEEF_0000_0000_0000, 4'b1000, 16'hBEEF, 4'b0000, 1'b1, "trk");
        cyc(1'b0, 4'b1000, 64'hCAFE_0000_0000_0000, 4'b1000, 16'hCAFE, 4'b0000, 1'b1, "trk");
        cyc(1'b0, 4'b1000, 64'hCAFE_0000_0000_0000, 4'b1000, 16'hCAFE, 4'b0000, 1'b1, "trk");
        cyc(1'b0, 4'b0000, 64'h1357_0000_0000_0000, 4'b1000, 16'hCAFE, 4'b0000, 1'b1, "trk");
        cyc(1'b0, 4'b0000, 64'h1357_0000_0000_0000, 4'b0000, 16'hCAFE, 4'b1000, 1'b0, "trk");

        // Reset mid-slot at counter 2: clean state, no pulse, source 0 first.
        do_reset("rstm");
        cyc(1'b0, 4'b0001, D12, 4'b0001, 16'h1234, 4'b0000, 1'b1, "mid");
        cyc(1'b0, 4'b0001, D12, 4'b0001, 16'h1234, 4'b0000, 1'b1, "mid");
        cyc(1'b0, 4'b0001, D12, 4'b0001, 16'h1234, 4'b0000, 1'b1, "mid");
        cyc(1'b1, 4'b0001, D12, 4'b0000, 16'h0000, 4'b0000, 1'b0, "midrst");
        cyc(1'b0, 4'b1111, D4,  4'b0001, 16'h1111, 4'b0000, 1'b1, "after");
        cyc(1'b0, 4'b1111, D4,  4'b0001, 16'h1111, 4'b0000, 1'b1, "after");

        @(posedge gclock);
        #2;
        chk("drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
